// File: rtl/mha_pkg.sv
// Shared MHA datapath definitions: default row geometry, the score_max_sub
// state encoding and the saturation helper used by the row subtractor.
package mha_pkg;

  localparam int MHA_D_W = 8;
  localparam int MHA_NUM = 16;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SUB  = 2'd1,
    S_HOLD = 2'd2
  } score_max_sub_state_e;

  // True when val falls below the most negative w-bit signed value.
  // The row differences are never positive, so only the low clamp exists.
  function automatic logic sat_below_min(input logic signed [31:0] val,
                                         input int unsigned w);
    logic signed [31:0] lim;
    lim = -(32'sd1 <<< (w - 1));
    return val < lim;
  endfunction

endpackage

// File: rtl/row_sat_sub.sv
// Combinational row-minus-scalar with clamp to the most negative D_W value.
module row_sat_sub
  import mha_pkg::*;
#(
  parameter int D_W = MHA_D_W,
  parameter int NUM = MHA_NUM
) (
  input  logic [0:NUM-1][D_W-1:0] row,
  input  logic [D_W-1:0]          scl,
  output logic [0:NUM-1][D_W-1:0] res
);

  logic signed [D_W:0] diff [NUM];

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      diff[i] = $signed({row[i][D_W-1], row[i]}) - $signed({scl[D_W-1], scl});
      res[i]  = sat_below_min(32'(diff[i]), D_W) ? {1'b1, {(D_W-1){1'b0}}}
                                                 : diff[i][D_W-1:0];
    end
  end

endmodule

// File: rtl/score_max_sub.sv
// Buffers one serial score row, tracks its maximum, then presents the
// max-subtracted row to the softmax and holds it until softmax completion.
//
// state  | meaning
// S_LOAD | accepting serial words, updating running max
// S_SUB  | one cycle: register row minus max into O_DATA, raise O_START
// S_HOLD | O_DATA/O_START frozen until softmax pulses I_SM_VLD
module score_max_sub
  import mha_pkg::*;
#(
  parameter int D_W = MHA_D_W,
  parameter int NUM = MHA_NUM
) (
  input  logic                    I_CLK,
  input  logic                    I_RST_N,
  input  logic                    I_VLD,
  input  logic [D_W-1:0]          I_DATA,
  output logic                    O_RDY,
  input  logic                    I_FLUSH,
  output logic                    O_START,
  output logic [0:NUM-1][D_W-1:0] O_DATA,
  input  logic                    I_SM_VLD
);

  localparam int CNT_W = $clog2(NUM);

  score_max_sub_state_e           state_q, state_nxt;
  logic [CNT_W-1:0]               cnt_q;
  logic [D_W-1:0]                 max_q, max_nxt;
  logic [0:NUM-1][D_W-1:0]        row_q;
  logic [0:NUM-1][D_W-1:0]        sub_res;
  logic                           xfer;
  logic                           last;

  assign xfer = I_VLD && O_RDY;
  assign last = (cnt_q == CNT_W'(NUM - 1));

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state_q <= S_LOAD;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (I_FLUSH) begin
      state_nxt = S_LOAD;
    end else begin
      unique case (state_q)
        S_LOAD:  if (xfer && last) state_nxt = S_SUB;
        S_SUB:   state_nxt = S_HOLD;
        S_HOLD:  if (I_SM_VLD) state_nxt = S_LOAD;
        default: state_nxt = S_LOAD;
      endcase
    end
  end

  always_comb begin
    O_RDY = (state_q == S_LOAD);
  end

  // First word of a row seeds the max so nothing carries over between rows.
  always_comb begin
    max_nxt = max_q;
    if (cnt_q == '0)                          max_nxt = I_DATA;
    else if ($signed(I_DATA) > $signed(max_q)) max_nxt = I_DATA;
  end

  row_sat_sub #(
    .D_W (D_W),
    .NUM (NUM)
  ) u_row_sat_sub (
    .row (row_q),
    .scl (max_q),
    .res (sub_res)
  );

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      cnt_q   <= '0;
      max_q   <= '0;
      row_q   <= '0;
      O_START <= 1'b0;
      O_DATA  <= '0;
    end else if (I_FLUSH) begin
      cnt_q   <= '0;
      max_q   <= '0;
      O_START <= 1'b0;
      O_DATA  <= '0;
    end else begin
      if (xfer) begin
        row_q[cnt_q] <= I_DATA;
        max_q        <= max_nxt;
        cnt_q        <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        S_SUB: begin
          O_DATA  <= sub_res;
          O_START <= 1'b1;
        end
        S_HOLD: begin
          if (I_SM_VLD) begin
            O_DATA  <= '0;
            O_START <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_max_sub.sv
// Self-checking bench for score_max_sub: directed rows plus random rows
// compared against a row-level max/subtract/clamp reference model.
module tb_score_max_sub;

  localparam int D_W = 8;
  localparam int NUM = 16;

  logic                    I_CLK = 1'b0;
  logic                    I_RST_N;
  logic                    I_VLD;
  logic [D_W-1:0]          I_DATA;
  logic                    O_RDY;
  logic                    I_FLUSH;
  logic                    O_START;
  logic [0:NUM-1][D_W-1:0] O_DATA;
  logic                    I_SM_VLD;

  int n_chk = 0;
  int n_err = 0;
  int row_w [NUM];
  int exp_o [NUM];
  logic [0:NUM-1][D_W-1:0] exp_vec;

  always #5 I_CLK = ~I_CLK;

  score_max_sub #(.D_W(D_W), .NUM(NUM)) dut (
    .I_CLK    (I_CLK),
    .I_RST_N  (I_RST_N),
    .I_VLD    (I_VLD),
    .I_DATA   (I_DATA),
    .O_RDY    (O_RDY),
    .I_FLUSH  (I_FLUSH),
    .O_START  (O_START),
    .O_DATA   (O_DATA),
    .I_SM_VLD (I_SM_VLD)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: row max, subtract, clamp at -2^(D_W-1).
  task automatic calc_ref();
    int m;
    int e;
    m = row_w[0];
    for (int i = 1; i < NUM; i++) if (row_w[i] > m) m = row_w[i];
    for (int i = 0; i < NUM; i++) begin
      e = row_w[i] - m;
      if (e < -(1 << (D_W - 1))) e = -(1 << (D_W - 1));
      exp_o[i]   = e & ((1 << D_W) - 1);
      exp_vec[i] = D_W'(exp_o[i]);
    end
  endtask

  task automatic push(input int w, input bit flush, input bit sm_noise);
    I_VLD    = 1'b1;
    I_DATA   = D_W'(w);
    I_FLUSH  = flush;
    I_SM_VLD = sm_noise ? 1'($urandom % 2) : 1'b0;
    @(posedge I_CLK); #1;
    I_VLD    = 1'b0;
    I_FLUSH  = 1'b0;
    I_SM_VLD = 1'b0;
  endtask

  task automatic load_row(input bit gapped, input bit sm_noise);
    calc_ref();
    check("rdy_load", 128'(O_RDY), 128'(1));
    for (int i = 0; i < NUM; i++) begin
      push(row_w[i], 1'b0, sm_noise);
      if (gapped && i != NUM - 1) begin
        @(posedge I_CLK); #1;
      end
    end
    check("start_sub", 128'(O_START), 128'(0));
    check("rdy_sub", 128'(O_RDY), 128'(0));
    I_VLD  = 1'b1;
    I_DATA = D_W'($urandom);
    @(posedge I_CLK); #1;
    I_VLD  = 1'b0;
    check("start_rise", 128'(O_START), 128'(1));
    check("rdy_hold", 128'(O_RDY), 128'(0));
    for (int i = 0; i < NUM; i++) check($sformatf("data%0d", i), 128'(O_DATA[i]), 128'(exp_o[i]));
  endtask

  task automatic hold_release(input int lat);
    for (int c = 0; c < lat; c++) begin
      I_VLD  = 1'($urandom % 2);
      I_DATA = D_W'($urandom);
      @(posedge I_CLK); #1;
      check("start_hold", 128'(O_START), 128'(1));
      check("data_hold", 128'(O_DATA), 128'(exp_vec));
    end
    I_VLD    = 1'b0;
    I_SM_VLD = 1'b1;
    @(posedge I_CLK); #1;
    I_SM_VLD = 1'b0;
    check("start_fall", 128'(O_START), 128'(0));
    check("data_clr", 128'(O_DATA), 128'(0));
    check("rdy_back", 128'(O_RDY), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_RST_N  = 1'b0;
    I_VLD    = 1'b0;
    I_DATA   = '0;
    I_FLUSH  = 1'b0;
    I_SM_VLD = 1'b0;
    #12;
    check("rst_rdy", 128'(O_RDY), 128'(1));
    check("rst_start", 128'(O_START), 128'(0));
    check("rst_data", 128'(O_DATA), 128'(0));
    @(posedge I_CLK); #1;
    I_RST_N = 1'b1;

    // ramp
    for (int i = 0; i < NUM; i++) row_w[i] = 16 + i;
    load_row(1'b0, 1'b0);
    hold_release(6);

    // saturation
    row_w[0] = 127;
    for (int i = 1; i < NUM; i++) row_w[i] = -128;
    load_row(1'b0, 1'b0);
    hold_release(5);

    for (int i = 0; i < NUM; i++) row_w[i] = -123;
    load_row(1'b0, 1'b0);
    hold_release(4);

    // gapped ramp
    for (int i = 0; i < NUM; i++) row_w[i] = 16 + i;
    load_row(1'b1, 1'b0);
    hold_release(6);

    // all 0xC0 after positive rows
    for (int i = 0; i < NUM; i++) row_w[i] = -64;
    load_row(1'b0, 1'b0);
    hold_release(3);

    // reset mid-row
    for (int i = 0; i < 7; i++) push(127, 1'b0, 1'b0);
    I_RST_N = 1'b0;
    #2;
    I_RST_N = 1'b1;
    check("midrst_rdy", 128'(O_RDY), 128'(1));
    for (int i = 0; i < NUM; i++) row_w[i] = i + 1;
    load_row(1'b0, 1'b0);
    hold_release(6);

    // flush in hold
    for (int i = 0; i < NUM; i++) row_w[i] = 40 - 3 * i;
    load_row(1'b0, 1'b0);
    @(posedge I_CLK); #1;
    I_FLUSH = 1'b1;
    @(posedge I_CLK); #1;
    I_FLUSH = 1'b0;
    check("flush_start", 128'(O_START), 128'(0));
    check("flush_data", 128'(O_DATA), 128'(0));
    check("flush_rdy", 128'(O_RDY), 128'(1));

    // flush coincident with the last transfer
    for (int i = 0; i < NUM - 1; i++) push(100, 1'b0, 1'b0);
    push(100, 1'b1, 1'b0);
    check("flushlast_rdy", 128'(O_RDY), 128'(1));
    @(posedge I_CLK); #1;
    check("flushlast_start", 128'(O_START), 128'(0));
    check("flushlast_rdy2", 128'(O_RDY), 128'(1));
    for (int i = 0; i < NUM; i++) row_w[i] = (i == 5) ? -20 : -100 + i;
    load_row(1'b0, 1'b0);
    hold_release(6);

    // random rows
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NUM; i++) row_w[i] = int'($urandom_range(255)) - 128;
      load_row(1'($urandom % 2), 1'($urandom % 2));
      hold_release(int'($urandom_range(8, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
